// File: rtl/axi_read_slave.sv
// AXI3 read-channel slave. It accepts one AR burst at a time and streams the beats on R
// from an internal word memory, which is loaded through a backdoor write port.
module axi_read_slave #(
  parameter int                ID_W      = 4,
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                MEM_DEPTH = 256,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         arvalid,
  output logic                         arready,
  input  logic [ID_W-1:0]              arid,
  input  logic [ADDR_W-1:0]            araddr,
  input  logic [3:0]                   arlen,
  input  logic [2:0]                   arsize,
  input  logic [1:0]                   arburst,
  output logic                         rvalid,
  input  logic                         rready,
  output logic [ID_W-1:0]              rid,
  output logic [DATA_W-1:0]            rdata,
  output logic [1:0]                   rresp,
  output logic                         rlast,
  input  logic                         mem_we,
  input  logic [$clog2(MEM_DEPTH)-1:0] mem_waddr,
  input  logic [DATA_W-1:0]            mem_wdata
);

  localparam int LANE_B  = DATA_W / 8;
  localparam int LANE_SH = $clog2(LANE_B);
  localparam int MIDX_W  = $clog2(MEM_DEPTH);

  typedef enum logic {IDLE, BURST} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        len_q;
  logic [2:0]        size_q;
  logic [1:0]        burst_q;
  logic [3:0]        cnt_q;
  logic              slverr_q;
  logic              arready_q;
  logic              rvalid_q;
  logic              rlast_q;
  logic [ID_W-1:0]   rid_q;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0]        rresp_q;

  logic [DATA_W-1:0] mem_q [MEM_DEPTH];

  logic [ADDR_W-1:0] stepBytes;
  logic [ADDR_W-1:0] wrapBytes;
  logic [ADDR_W-1:0] nextAddr_d;
  logic              arSlverr_d;
  logic [ADDR_W-1:0] lookAddr;
  logic              lookSlv;
  logic              underflow;
  logic [ADDR_W-1:0] offset;
  logic [ADDR_W-1:0] wordIdx;
  logic              decErr;
  logic [DATA_W-1:0] beatData_d;
  logic [1:0]        beatResp_d;

  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rlast   = rlast_q;
  assign rid     = rid_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;

  // Address of the beat after the one currently presented; WRAP stays inside its aligned window.
  always_comb begin
    stepBytes = ADDR_W'(1) << size_q;
    wrapBytes = (ADDR_W'(len_q) + ADDR_W'(1)) << size_q;
    unique case (burst_q)
      2'b00:   nextAddr_d = addr_q;
      2'b10:   nextAddr_d = (addr_q & ~(wrapBytes - ADDR_W'(1))) |
                            ((addr_q + stepBytes) & (wrapBytes - ADDR_W'(1)));
      default: nextAddr_d = addr_q + stepBytes;
    endcase
  end

  always_comb begin
    arSlverr_d = 1'b0;
    if (arburst == 2'b11) arSlverr_d = 1'b1;
    if (arsize > 3'(LANE_SH)) arSlverr_d = 1'b1;
    if (arburst == 2'b10) begin
      if (!(arlen inside {4'd1, 4'd3, 4'd7, 4'd15})) arSlverr_d = 1'b1;
      if ((araddr & ((ADDR_W'(1) << arsize) - ADDR_W'(1))) != '0) arSlverr_d = 1'b1;
    end
  end

  // The same lookup produces beat 0 at the AR handshake and every later beat at acceptance.
  always_comb begin
    lookAddr = (state_q == IDLE) ? araddr : nextAddr_d;
    lookSlv  = (state_q == IDLE) ? arSlverr_d : slverr_q;
    {underflow, offset} = {1'b0, lookAddr} - {1'b0, BASE_ADDR};
    wordIdx  = offset >> LANE_SH;
    decErr   = underflow || (wordIdx >= ADDR_W'(MEM_DEPTH));
    beatData_d = '0;
    beatResp_d = 2'b00;
    if (lookSlv) begin
      beatResp_d = 2'b10;
    end else if (decErr) begin
      beatResp_d = 2'b11;
    end else begin
      beatData_d = mem_q[wordIdx[MIDX_W-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      cnt_q     <= '0;
      slverr_q  <= 1'b0;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rid_q     <= '0;
      rdata_q   <= '0;
      rresp_q   <= 2'b00;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (arvalid && arready_q) begin
            addr_q    <= araddr;
            len_q     <= arlen;
            size_q    <= arsize;
            burst_q   <= arburst;
            slverr_q  <= arSlverr_d;
            cnt_q     <= '0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            rid_q     <= arid;
            rdata_q   <= beatData_d;
            rresp_q   <= beatResp_d;
            rlast_q   <= (arlen == 4'd0);
            state_q   <= BURST;
          end
        end
        BURST: begin
          if (rready) begin
            if (cnt_q == len_q) begin
              rvalid_q  <= 1'b0;
              rlast_q   <= 1'b0;
              arready_q <= 1'b1;
              state_q   <= IDLE;
            end else begin
              addr_q  <= nextAddr_d;
              cnt_q   <= cnt_q + 4'd1;
              rdata_q <= beatData_d;
              rresp_q <= beatResp_d;
              rlast_q <= ((cnt_q + 4'd1) == len_q);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_read_slave.sv
// Bench for axi_read_slave: a reference model pushes expected beats into a queue and an R-channel
// monitor pops and compares them, with hand-written sequences for timing, backdoor and reset cases.
module tb_axi_read_slave;

  localparam int ID_W      = 4;
  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int MEM_DEPTH = 256;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              arvalid = 1'b0;
  logic              arready;
  logic [ID_W-1:0]   arid = '0;
  logic [ADDR_W-1:0] araddr = '0;
  logic [3:0]        arlen = '0;
  logic [2:0]        arsize = '0;
  logic [1:0]        arburst = '0;
  logic              rvalid;
  logic              rready = 1'b0;
  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              mem_we = 1'b0;
  logic [7:0]        mem_waddr = '0;
  logic [DATA_W-1:0] mem_wdata = '0;

  always #5 clk = ~clk;

  axi_read_slave #(
    .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_DEPTH(MEM_DEPTH), .BASE_ADDR(32'h0)
  ) dut (
    .clk(clk), .rst(rst),
    .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr),
    .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata)
  );

  typedef struct {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [3:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [15:0] readyPat;
    logic        expSlv;
  } vec_t;

  typedef struct {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  beat_t       expQ[$];
  logic [31:0] tbMem [MEM_DEPTH];
  int          total = 0;
  int          bad = 0;
  vec_t        vecs[12];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Reference beats: WRAP is modelled as "linear address, pulled back by one window when past it".
  task automatic pushBeats(input vec_t v);
    longint step, wsize, start, lower, a;
    beat_t  b;
    step  = longint'(1) << v.size;
    wsize = (longint'(v.len) + 1) * step;
    start = longint'(v.addr);
    lower = (start / wsize) * wsize;
    for (int i = 0; i <= int'(v.len); i++) begin
      if (v.burst == 2'b00) a = start;
      else a = start + longint'(i) * step;
      if (v.burst == 2'b10 && a >= lower + wsize) a = a - wsize;
      b.id   = v.id;
      b.last = (i == int'(v.len));
      if (v.expSlv) begin
        b.resp = 2'b10;
        b.data = '0;
      end else if (a / 4 >= MEM_DEPTH) begin
        b.resp = 2'b11;
        b.data = '0;
      end else begin
        b.resp = 2'b00;
        b.data = tbMem[int'(a / 4)];
      end
      expQ.push_back(b);
    end
  endtask

  beat_t monE;
  beat_t prevBeat;
  logic  prevStall = 1'b0;

  // R-channel monitor: compares accepted beats against the queue and checks stalled beats hold.
  always @(negedge clk) begin
    if (!rst) begin
      prevStall = 1'b0;
    end else begin
      if (prevStall) begin
        checkOutput("hold_rvalid", rvalid, 1'b1);
        checkOutput("hold_rid", rid, prevBeat.id);
        checkOutput("hold_rdata", rdata, prevBeat.data);
        checkOutput("hold_rresp", rresp, prevBeat.resp);
        checkOutput("hold_rlast", rlast, prevBeat.last);
      end
      if (rvalid && rready) begin
        if (expQ.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_beat: got rdata=%0h expected no beat", rdata);
        end else begin
          monE = expQ.pop_front();
          checkOutput("rid", rid, monE.id);
          checkOutput("rdata", rdata, monE.data);
          checkOutput("rresp", rresp, monE.resp);
          checkOutput("rlast", rlast, monE.last);
        end
      end
      prevStall = rvalid && !rready;
      prevBeat  = '{rid, rdata, rresp, rlast};
    end
  end

  task automatic driveAr(input vec_t v);
    arvalid = 1'b1;
    arid    = v.id;
    araddr  = v.addr;
    arlen   = v.len;
    arsize  = v.size;
    arburst = v.burst;
  endtask

  task automatic drainQueue(input string tag);
    int guard;
    guard = 0;
    rready = 1'b1;
    while (expQ.size() != 0 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    checkOutput({tag, "_beats_left"}, 64'(expQ.size()), 0);
    expQ.delete();
    rready = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v, input string tag);
    int guard;
    int k;
    pushBeats(v);
    @(posedge clk); #1;
    driveAr(v);
    rready = 1'b0;
    guard = 0;
    while (!arready && guard < 40) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!arready) begin
      checkOutput({tag, "_ar_timeout"}, 0, 1);
      arvalid = 1'b0;
      expQ.delete();
      return;
    end
    @(posedge clk); #1;
    arvalid = 1'b0;
    k = 0;
    guard = 0;
    while (expQ.size() != 0 && guard < 200) begin
      rready = v.readyPat[k % 16];
      k++;
      guard++;
      @(posedge clk); #1;
    end
    checkOutput({tag, "_beats_left"}, 64'(expQ.size()), 0);
    checkOutput({tag, "_arready_after"}, arready, 1'b1);
    checkOutput({tag, "_rvalid_after"}, rvalid, 1'b0);
    expQ.delete();
    rready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t v;
    vecs[0]  = '{4'd1,  32'h008, 4'd3,  3'd2, 2'b10, 16'hFFFF, 1'b0};
    vecs[1]  = '{4'd2,  32'h004, 4'd2,  3'd2, 2'b00, 16'hFFFF, 1'b0};
    vecs[2]  = '{4'd3,  32'h010, 4'd3,  3'd2, 2'b01, 16'hFFF9, 1'b0};
    vecs[3]  = '{4'd4,  32'h3FC, 4'd1,  3'd2, 2'b01, 16'hFFFF, 1'b0};
    vecs[4]  = '{4'd6,  32'h000, 4'd1,  3'd2, 2'b11, 16'hFFFF, 1'b1};
    vecs[5]  = '{4'd7,  32'h000, 4'd0,  3'd3, 2'b01, 16'hFFFF, 1'b1};
    vecs[6]  = '{4'd8,  32'h000, 4'd2,  3'd2, 2'b10, 16'hFFFF, 1'b1};
    vecs[7]  = '{4'd9,  32'h006, 4'd3,  3'd2, 2'b10, 16'hFFFF, 1'b1};
    vecs[8]  = '{4'd10, 32'h014, 4'd7,  3'd2, 2'b10, 16'hB6DB, 1'b0};
    vecs[9]  = '{4'd11, 32'h021, 4'd7,  3'd0, 2'b01, 16'hFFFF, 1'b0};
    vecs[10] = '{4'd12, 32'h100, 4'd15, 3'd1, 2'b01, 16'h7EFF, 1'b0};
    vecs[11] = '{4'd13, 32'h3F8, 4'd3,  3'd2, 2'b01, 16'hFFFF, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_arready", arready, 1'b1);
    checkOutput("rst_rvalid", rvalid, 1'b0);
    checkOutput("rst_rlast", rlast, 1'b0);
    checkOutput("rst_rid", rid, 0);
    checkOutput("rst_rdata", rdata, 0);
    checkOutput("rst_rresp", rresp, 0);
    @(negedge clk);
    rst = 1'b1;

    // Backdoor preload of the whole memory with distinct words.
    for (int i = 0; i < MEM_DEPTH; i++) begin
      @(posedge clk); #1;
      tbMem[i]  = 32'hA000_0000 + 32'(i) * 32'h0001_0203;
      mem_we    = 1'b1;
      mem_waddr = 8'(i);
      mem_wdata = tbMem[i];
    end
    @(posedge clk); #1;
    mem_we = 1'b0;

    // Back-to-back INCR burst: beats on consecutive cycles starting one cycle after AR.
    v = '{4'd5, 32'h0, 4'd3, 3'd2, 2'b01, 16'hFFFF, 1'b0};
    pushBeats(v);
    checkOutput("t1_arready_idle", arready, 1'b1);
    driveAr(v);
    rready = 1'b1;
    @(posedge clk); #1;
    arvalid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("t1_rvalid", rvalid, 1'b1);
      checkOutput("t1_rlast", rlast, (k == 3));
      checkOutput("t1_arready_busy", arready, 1'b0);
    end
    @(negedge clk);
    checkOutput("t1_rvalid_end", rvalid, 1'b0);
    checkOutput("t1_arready_end", arready, 1'b1);
    checkOutput("t1_beats_left", 64'(expQ.size()), 0);
    expQ.delete();
    rready = 1'b0;

    for (int i = 0; i < 12; i++) applyStimulus(vecs[i], $sformatf("vec%0d", i));

    // Backdoor write to word 0 on the AR handshake edge: this burst sees the old word.
    v = '{4'd14, 32'h0, 4'd0, 3'd2, 2'b01, 16'hFFFF, 1'b0};
    pushBeats(v);
    @(posedge clk); #1;
    driveAr(v);
    mem_we    = 1'b1;
    mem_waddr = 8'd0;
    mem_wdata = 32'hDEAD_BEEF;
    rready    = 1'b1;
    @(posedge clk); #1;
    arvalid  = 1'b0;
    mem_we   = 1'b0;
    tbMem[0] = 32'hDEAD_BEEF;
    drainQueue("bd_old");
    applyStimulus('{4'd15, 32'h0, 4'd0, 3'd2, 2'b01, 16'hFFFF, 1'b0}, "bd_new");

    // Reset asserted after two beats of an eight-beat burst.
    v = '{4'd10, 32'h40, 4'd7, 3'd2, 2'b01, 16'hFFFF, 1'b0};
    pushBeats(v);
    @(posedge clk); #1;
    driveAr(v);
    rready = 1'b1;
    @(posedge clk); #1;
    arvalid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    checkOutput("mrst_rvalid", rvalid, 1'b0);
    checkOutput("mrst_rlast", rlast, 1'b0);
    checkOutput("mrst_pending", 64'(expQ.size()), 6);
    expQ.delete();
    rready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("mrst_arready", arready, 1'b1);
    checkOutput("mrst_rvalid_idle", rvalid, 1'b0);
    applyStimulus('{4'd3, 32'h20, 4'd0, 3'd2, 2'b01, 16'hFFFF, 1'b0}, "post_rst");

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
